// File: rtl/sprite_row_dispatcher_pkg.sv
// Shared types and constants for the sprite row dispatcher.
// Sprite entry layout, grid geometry, FSM state encoding.
package sprite_row_dispatcher_pkg;

  localparam int SPR_W         = 23;
  localparam int SPR_VALID_BIT = 22;
  localparam int SPR_TEX_LSB   = 18;
  localparam int SPR_SX_LSB    = 13;
  localparam int SPR_SY_LSB    = 8;
  localparam int SPR_Z_LSB     = 0;

  localparam int GRID_DIM      = 16;
  localparam int COORD_OFFSET  = 16;
  localparam logic [7:0] BG_Z  = 8'd0;

  typedef enum logic [2:0] {
    IDLE,
    SPR_RD,
    SPR_CHK,
    SPR_TEX,
    BG_RD,
    BG_TEX
  } state_t;

endpackage

// File: rtl/sprite_row_dispatcher_if.sv
// Broadcast bus from the dispatcher to the processor array.
// master drives texture row, start_x/y, z and one-hot row enable.
interface sprite_row_dispatcher_if;

  logic [127:0] o_texture_data;
  logic [4:0]   o_start_x;
  logic [4:0]   o_start_y;
  logic [7:0]   o_position_z;
  logic [15:0]  o_row_ena;

  modport master (
    output o_texture_data,
    output o_start_x,
    output o_start_y,
    output o_position_z,
    output o_row_ena
  );

  modport slave (
    input o_texture_data,
    input o_start_x,
    input o_start_y,
    input o_position_z,
    input o_row_ena
  );

endinterface

// File: rtl/sprite_row_dispatcher_sprite_row_test.sv
// Combinational row coverage test for one sprite entry.
// In: grid row, start_y, valid, z. Out: visible, texture row.
module sprite_row_test
  import sprite_row_dispatcher_pkg::*;
(
  input  logic [3:0] i_row,
  input  logic [4:0] i_start_y,
  input  logic       i_valid,
  input  logic [7:0] i_z,
  output logic       o_visible,
  output logic [3:0] o_tex_row
);

  logic [4:0] w_rel;

  // Coordinates carry a +16 offset; a negative or >=16
  // distance shows up as bit 4 set after the mod-32 wrap.
  assign w_rel = 5'(COORD_OFFSET) + {1'b0, i_row} - i_start_y;

  assign o_visible = i_valid && (i_z != BG_Z) && !w_rel[4];
  assign o_tex_row = w_rel[3:0];

endmodule

// File: rtl/sprite_row_dispatcher.sv
// Walks the sprite table per grid row and broadcasts texture rows.
// Ports: clk/reset, frame start/busy/done, sprite rd, texture rd, bus.
module sprite_row_dispatcher
  import sprite_row_dispatcher_pkg::*;
#(
  parameter int SPRITE_COUNT = 8,
  parameter int SPR_ADDR_W   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_frame_start,
  input  logic [3:0]            i_bg_tex_id,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [SPR_ADDR_W-1:0] o_spr_addr,
  input  logic [SPR_W-1:0]      i_spr_data,
  output logic [7:0]            o_tex_addr,
  output logic                  o_tex_rd,
  input  logic [127:0]          i_tex_data,
  sprite_row_dispatcher_if.master bus
);

  state_t r_state;
  state_t w_state_nxt;

  logic [3:0]            r_row;
  logic [3:0]            r_bg;
  logic [SPR_ADDR_W-1:0] r_idx;
  logic [4:0]            r_sx;
  logic [4:0]            r_sy;
  logic [7:0]            r_z;
  logic [127:0]          r_tex_data;
  logic [4:0]            r_bsx;
  logic [4:0]            r_bsy;
  logic [7:0]            r_bz;
  logic [15:0]           r_row_ena;
  logic                  r_done;

  logic       w_valid;
  logic [3:0] w_tex;
  logic [4:0] w_sx;
  logic [4:0] w_sy;
  logic [7:0] w_z;
  logic       w_vis;
  logic [3:0] w_tex_row;
  logic       w_last_idx;
  logic       w_last_row;

  assign w_valid = i_spr_data[SPR_VALID_BIT];
  assign w_tex   = i_spr_data[SPR_TEX_LSB +: 4];
  assign w_sx    = i_spr_data[SPR_SX_LSB +: 5];
  assign w_sy    = i_spr_data[SPR_SY_LSB +: 5];
  assign w_z     = i_spr_data[SPR_Z_LSB +: 8];

  assign w_last_idx =
    (r_idx == SPR_ADDR_W'(SPRITE_COUNT - 1));
  assign w_last_row = (r_row == 4'(GRID_DIM - 1));

  sprite_row_test u_row_test (
    .i_row     (r_row),
    .i_start_y (w_sy),
    .i_valid   (w_valid),
    .i_z       (w_z),
    .o_visible (w_vis),
    .o_tex_row (w_tex_row)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_tex_rd    = 1'b0;
    o_tex_addr  = '0;
    unique case (r_state)
      IDLE: begin
        if (i_frame_start) begin
          w_state_nxt = SPR_RD;
        end
      end
      SPR_RD: begin
        w_state_nxt = SPR_CHK;
      end
      SPR_CHK: begin
        if (w_vis) begin
          o_tex_rd    = 1'b1;
          o_tex_addr  = {w_tex, w_tex_row};
          w_state_nxt = SPR_TEX;
        end else begin
          w_state_nxt = w_last_idx ? BG_RD : SPR_RD;
        end
      end
      SPR_TEX: begin
        w_state_nxt = w_last_idx ? BG_RD : SPR_RD;
      end
      BG_RD: begin
        o_tex_rd    = 1'b1;
        o_tex_addr  = {r_bg, r_row};
        w_state_nxt = BG_TEX;
      end
      BG_TEX: begin
        w_state_nxt = w_last_row ? IDLE : SPR_RD;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_row      <= '0;
      r_bg       <= '0;
      r_idx      <= '0;
      r_sx       <= '0;
      r_sy       <= '0;
      r_z        <= '0;
      r_tex_data <= '0;
      r_bsx      <= '0;
      r_bsy      <= '0;
      r_bz       <= '0;
      r_row_ena  <= '0;
      r_done     <= 1'b0;
    end else begin
      r_row_ena <= '0;
      r_done    <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (i_frame_start) begin
            r_bg  <= i_bg_tex_id;
            r_row <= '0;
            r_idx <= '0;
          end
        end
        SPR_CHK: begin
          // Hold the entry; the table output may move on.
          r_sx <= w_sx;
          r_sy <= w_sy;
          r_z  <= w_z;
          if (!w_vis && !w_last_idx) begin
            r_idx <= r_idx + 1'b1;
          end
        end
        SPR_TEX: begin
          r_tex_data <= i_tex_data;
          r_bsx      <= r_sx;
          r_bsy      <= r_sy;
          r_bz       <= r_z;
          r_row_ena  <= 16'h0001 << r_row;
          if (!w_last_idx) begin
            r_idx <= r_idx + 1'b1;
          end
        end
        BG_TEX: begin
          r_tex_data <= i_tex_data;
          r_bsx      <= 5'(COORD_OFFSET);
          r_bsy      <= 5'(COORD_OFFSET);
          r_bz       <= BG_Z;
          r_row_ena  <= 16'h0001 << r_row;
          if (w_last_row) begin
            r_done <= 1'b1;
          end else begin
            r_row <= r_row + 1'b1;
            r_idx <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Busy stays up through the cycle the done pulse is visible.
  assign o_busy     = (r_state != IDLE) || r_done;
  assign o_done     = r_done;
  assign o_spr_addr = r_idx;

  assign bus.o_texture_data = r_tex_data;
  assign bus.o_start_x      = r_bsx;
  assign bus.o_start_y      = r_bsy;
  assign bus.o_position_z   = r_bz;
  assign bus.o_row_ena      = r_row_ena;

endmodule

// File: tb/tb_sprite_row_dispatcher.sv
// Directed bench for sprite_row_dispatcher.
// Models sprite/texture memories, logs broadcasts, checks per test.
module tb_sprite_row_dispatcher;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         i_frame_start = 1'b0;
  logic [3:0]   i_bg_tex_id = 4'd0;
  logic         o_busy;
  logic         o_done;
  logic [2:0]   o_spr_addr;
  logic [22:0]  i_spr_data;
  logic [7:0]   o_tex_addr;
  logic         o_tex_rd;
  logic [127:0] i_tex_data;

  sprite_row_dispatcher_if bus ();

  sprite_row_dispatcher #(
    .SPRITE_COUNT (N),
    .SPR_ADDR_W   (3)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .i_frame_start (i_frame_start),
    .i_bg_tex_id   (i_bg_tex_id),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_spr_addr    (o_spr_addr),
    .i_spr_data    (i_spr_data),
    .o_tex_addr    (o_tex_addr),
    .o_tex_rd      (o_tex_rd),
    .i_tex_data    (i_tex_data),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]  cyc;
    logic [15:0]  ena;
    logic [7:0]   z;
    logic [4:0]   sx;
    logic [4:0]   sy;
    logic [127:0] tex;
  } rec_t;

  function automatic logic [127:0] exp_tex(
    input logic [3:0] id, input logic [3:0] row);
    return {16{id, row}};
  endfunction

  function automatic rec_t mk(input int c,
    input logic [15:0] e, input logic [7:0] z,
    input logic [4:0] sx, input logic [4:0] sy,
    input logic [127:0] t);
    rec_t r;
    r.cyc = c;
    r.ena = e;
    r.z   = z;
    r.sx  = sx;
    r.sy  = sy;
    r.tex = t;
    return r;
  endfunction

  function automatic logic [22:0] ent(input logic v,
    input logic [3:0] t, input logic [4:0] sx,
    input logic [4:0] sy, input logic [7:0] z);
    return {v, t, sx, sy, z};
  endfunction

  logic [22:0] spr_tab [N];

  always @(posedge clk) i_spr_data <= spr_tab[o_spr_addr];
  always @(posedge clk)
    if (o_tex_rd)
      i_tex_data <= exp_tex(o_tex_addr[7:4], o_tex_addr[3:0]);

  int cyc = 0;
  int base = 0;
  always @(posedge clk) cyc <= cyc + 1;

  rec_t recs[$];
  rec_t exq[$];
  int n_done, n_rd, done_cyc;
  int checks = 0;
  int failures = 0;

  always @(negedge clk) begin
    if (bus.o_row_ena != 16'h0)
      recs.push_back(mk(cyc - base, bus.o_row_ena,
        bus.o_position_z, bus.o_start_x, bus.o_start_y,
        bus.o_texture_data));
    if (o_done) begin
      n_done++;
      done_cyc = cyc - base;
    end
    if (o_tex_rd) n_rd++;
  end

  task automatic clear_tab();
    for (int i = 0; i < N; i++) spr_tab[i] = 23'h0;
  endtask

  // Cycle 1 is the negedge right after the start is sampled.
  task automatic start_frame(input logic [3:0] bg);
    recs.delete();
    exq.delete();
    n_done = 0;
    n_rd = 0;
    done_cyc = -1;
    @(negedge clk);
    i_frame_start = 1'b1;
    i_bg_tex_id = bg;
    @(negedge clk);
    i_frame_start = 1'b0;
    base = cyc - 1;
  endtask

  task automatic run_frame(input logic [3:0] bg,
    output bit ok, output logic b_done, output logic b_after);
    start_frame(bg);
    ok = 0;
    b_done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (o_done) begin
        ok = 1;
        break;
      end
    end
    b_done = o_busy;
    @(negedge clk);
    b_after = o_busy;
  endtask

  task automatic test_reset();
    clear_tab();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({o_busy, o_done, o_tex_rd} !== 3'b000) begin
      failures++;
      $display("FAIL rst_ctrl got=%b exp=000",
        {o_busy, o_done, o_tex_rd});
    end
    checks++;
    if (bus.o_row_ena !== 16'h0) begin
      failures++;
      $display("FAIL rst_ena got=%h exp=0000", bus.o_row_ena);
    end
    checks++;
    if ({bus.o_texture_data, bus.o_start_x, bus.o_start_y,
         bus.o_position_z, o_spr_addr} !== '0) begin
      failures++;
      $display("FAIL rst_bus got=%h/%0d/%0d/%0d exp=0",
        bus.o_texture_data, bus.o_start_x, bus.o_start_y,
        bus.o_position_z);
    end
    reset = 1'b0;
  endtask

  task automatic test_background();
    bit ok;
    logic b1, b2;
    clear_tab();
    run_frame(4'd3, ok, b1, b2);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL bg_timeout got=no_done exp=done");
    end
    checks++;
    if (b1 !== 1'b1 || b2 !== 1'b0) begin
      failures++;
      $display("FAIL bg_busy got=%b%b exp=10", b1, b2);
    end
    for (int r = 0; r < 16; r++)
      exq.push_back(mk(19 + 18 * r, 16'h1 << r, 8'd0,
        5'd16, 5'd16, exp_tex(4'd3, 4'(r))));
    checks++;
    if (recs.size() != exq.size()) begin
      failures++;
      $display("FAIL bg_count got=%0d exp=%0d",
        recs.size(), exq.size());
    end
    for (int i = 0; i < exq.size(); i++)
      if (i < recs.size()) begin
        checks++;
        if (recs[i] !== exq[i]) begin
          failures++;
          $display("FAIL bg_bcast[%0d] got=%h exp=%h",
            i, recs[i], exq[i]);
        end
      end
    checks++;
    if (n_done != 1 || done_cyc != 289) begin
      failures++;
      $display("FAIL bg_done got=%0d@%0d exp=1@289",
        n_done, done_cyc);
    end
    checks++;
    if (n_rd != 16) begin
      failures++;
      $display("FAIL bg_reads got=%0d exp=16", n_rd);
    end
  endtask

  task automatic test_single_sprite();
    bit ok;
    logic b1, b2;
    int s, len;
    clear_tab();
    spr_tab[2] = ent(1'b1, 4'd7, 5'd18, 5'd20, 8'd5);
    run_frame(4'd1, ok, b1, b2);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL one_timeout got=no_done exp=done");
    end
    s = 1;
    for (int r = 0; r < 16; r++) begin
      len = 18;
      if (r >= 4) begin
        exq.push_back(mk(s + 7, 16'h1 << r, 8'd5, 5'd18,
          5'd20, exp_tex(4'd7, 4'(r - 4))));
        len = 19;
      end
      exq.push_back(mk(s + len, 16'h1 << r, 8'd0, 5'd16,
        5'd16, exp_tex(4'd1, 4'(r))));
      s += len;
    end
    checks++;
    if (recs.size() != exq.size()) begin
      failures++;
      $display("FAIL one_count got=%0d exp=%0d",
        recs.size(), exq.size());
    end
    for (int i = 0; i < exq.size(); i++)
      if (i < recs.size()) begin
        checks++;
        if (recs[i] !== exq[i]) begin
          failures++;
          $display("FAIL one_bcast[%0d] got=%h exp=%h",
            i, recs[i], exq[i]);
        end
      end
    checks++;
    if (n_done != 1 || done_cyc != s) begin
      failures++;
      $display("FAIL one_done got=%0d@%0d exp=1@%0d",
        n_done, done_cyc, s);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    logic b1, b2;
    int s, len;
    clear_tab();
    spr_tab[0] = ent(1'b1, 4'd10, 5'd1, 5'd3, 8'd9);
    spr_tab[1] = ent(1'b1, 4'd2, 5'd0, 5'd0, 8'd4);
    run_frame(4'd8, ok, b1, b2);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL wrap_timeout got=no_done exp=done");
    end
    s = 1;
    for (int r = 0; r < 16; r++) begin
      len = 18;
      if (r <= 2) begin
        exq.push_back(mk(s + 3, 16'h1 << r, 8'd9, 5'd1,
          5'd3, exp_tex(4'd10, 4'(13 + r))));
        len = 19;
      end
      exq.push_back(mk(s + len, 16'h1 << r, 8'd0, 5'd16,
        5'd16, exp_tex(4'd8, 4'(r))));
      s += len;
    end
    checks++;
    if (recs.size() != exq.size()) begin
      failures++;
      $display("FAIL wrap_count got=%0d exp=%0d",
        recs.size(), exq.size());
    end
    for (int i = 0; i < exq.size(); i++)
      if (i < recs.size()) begin
        checks++;
        if (recs[i] !== exq[i]) begin
          failures++;
          $display("FAIL wrap_bcast[%0d] got=%h exp=%h",
            i, recs[i], exq[i]);
        end
      end
    checks++;
    if (n_rd != 19 || done_cyc != s) begin
      failures++;
      $display("FAIL wrap_rd_done got=%0d@%0d exp=19@%0d",
        n_rd, done_cyc, s);
    end
  endtask

  task automatic test_zero_z();
    bit ok;
    logic b1, b2;
    clear_tab();
    spr_tab[4] = ent(1'b1, 4'd5, 5'd3, 5'd16, 8'd0);
    run_frame(4'd6, ok, b1, b2);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL z0_timeout got=no_done exp=done");
    end
    for (int r = 0; r < 16; r++)
      exq.push_back(mk(19 + 18 * r, 16'h1 << r, 8'd0,
        5'd16, 5'd16, exp_tex(4'd6, 4'(r))));
    checks++;
    if (recs.size() != exq.size()) begin
      failures++;
      $display("FAIL z0_count got=%0d exp=%0d",
        recs.size(), exq.size());
    end
    for (int i = 0; i < exq.size(); i++)
      if (i < recs.size()) begin
        checks++;
        if (recs[i] !== exq[i]) begin
          failures++;
          $display("FAIL z0_bcast[%0d] got=%h exp=%h",
            i, recs[i], exq[i]);
        end
      end
    checks++;
    if (n_rd != 16 || done_cyc != 289) begin
      failures++;
      $display("FAIL z0_rd_done got=%0d@%0d exp=16@289",
        n_rd, done_cyc);
    end
  endtask

  task automatic test_overlap();
    bit ok;
    logic b1, b2;
    int s, len;
    bit h0, h5;
    clear_tab();
    spr_tab[0] = ent(1'b1, 4'd1, 5'd2, 5'd23, 8'd7);
    spr_tab[5] = ent(1'b1, 4'd6, 5'd30, 5'd8, 8'd3);
    run_frame(4'd12, ok, b1, b2);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL ovl_timeout got=no_done exp=done");
    end
    s = 1;
    for (int r = 0; r < 16; r++) begin
      h0 = (r >= 7);
      h5 = (r <= 7);
      len = 18 + int'(h0) + int'(h5);
      if (h0)
        exq.push_back(mk(s + 3, 16'h1 << r, 8'd7, 5'd2,
          5'd23, exp_tex(4'd1, 4'(r - 7))));
      if (h5)
        exq.push_back(mk(s + (h0 ? 14 : 13), 16'h1 << r,
          8'd3, 5'd30, 5'd8, exp_tex(4'd6, 4'(r + 8))));
      exq.push_back(mk(s + len, 16'h1 << r, 8'd0, 5'd16,
        5'd16, exp_tex(4'd12, 4'(r))));
      s += len;
    end
    checks++;
    if (recs.size() != exq.size()) begin
      failures++;
      $display("FAIL ovl_count got=%0d exp=%0d",
        recs.size(), exq.size());
    end
    for (int i = 0; i < exq.size(); i++)
      if (i < recs.size()) begin
        checks++;
        if (recs[i] !== exq[i]) begin
          failures++;
          $display("FAIL ovl_bcast[%0d] got=%h exp=%h",
            i, recs[i], exq[i]);
        end
      end
    checks++;
    if (n_done != 1 || done_cyc != s) begin
      failures++;
      $display("FAIL ovl_done got=%0d@%0d exp=1@%0d",
        n_done, done_cyc, s);
    end
  endtask

  task automatic test_restart();
    bit ok;
    logic b1, b2;
    clear_tab();
    start_frame(4'd2);
    repeat (100) @(negedge clk);
    i_frame_start = 1'b1;
    i_bg_tex_id = 4'd5;
    @(negedge clk);
    i_frame_start = 1'b0;
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (o_done) begin
        ok = 1;
        break;
      end
    end
    repeat (5) @(negedge clk);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL ign_timeout got=no_done exp=done");
    end
    checks++;
    if (n_done != 1 || done_cyc != 289 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL ign_done got=%0d@%0d busy=%b exp=1@289 0",
        n_done, done_cyc, o_busy);
    end
    checks++;
    if (recs.size() != 16) begin
      failures++;
      $display("FAIL ign_count got=%0d exp=16", recs.size());
    end else begin
      checks++;
      if (recs[15].tex !== exp_tex(4'd2, 4'd15)) begin
        failures++;
        $display("FAIL ign_bg got=%h exp=%h",
          recs[15].tex, exp_tex(4'd2, 4'd15));
      end
    end
    start_frame(4'd4);
    repeat (40) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({o_busy, o_done, o_tex_rd} !== 3'b000 ||
        bus.o_row_ena !== 16'h0) begin
      failures++;
      $display("FAIL abort_ctrl got=%b ena=%h exp=000 0000",
        {o_busy, o_done, o_tex_rd}, bus.o_row_ena);
    end
    checks++;
    if ({bus.o_texture_data, bus.o_start_x, bus.o_start_y,
         bus.o_position_z} !== '0) begin
      failures++;
      $display("FAIL abort_bus got=%h exp=0",
        bus.o_texture_data);
    end
    reset = 1'b0;
    run_frame(4'd9, ok, b1, b2);
    checks++;
    if (!ok || done_cyc != 289 || recs.size() != 16) begin
      failures++;
      $display("FAIL after_rst got=%0d@%0d n=%0d exp=1@289 n=16",
        ok, done_cyc, recs.size());
    end else begin
      checks++;
      if (recs[15] !== mk(289, 16'h8000, 8'd0, 5'd16, 5'd16,
          exp_tex(4'd9, 4'd15))) begin
        failures++;
        $display("FAIL after_rst_last got=%h", recs[15]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_background();
    test_single_sprite();
    test_wrap();
    test_zero_z();
    test_overlap();
    test_restart();
    $display("TB_RESULT checks=%0d failures=%0d",
      checks, failures);
    $finish;
  end

endmodule
